// File: rtl/ppu_vram_arbiter.sv
// Shares the single PPU VRAM port between renderer fetches (always first) and CPU $2007 accesses.
// Define VRAM_ARB_STATS_EN to build the saturating stall_cnt counter; otherwise stall_cnt reads 0.
module ppu_vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rend_active,
    input  logic [ADDR_W-1:0] rend_addr,
    output logic [DATA_W-1:0] rend_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    // state    | meaning
    // IDLE     | bus follows the renderer; a CPU request is taken in a cycle the renderer leaves free
    // CPU_ACC  | latched CPU access drives VRAM, unless the renderer reclaims the bus (abort)
    // CPU_DONE | ack pulse; read data for the CPU_ACC address arrives from VRAM this cycle
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        CPU_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] a_q;
    logic              we_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              cpu_drive;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cpu_drive = 1'b0;
        cpu_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !rend_active) begin
                    accept    = 1'b1;
                    state_nxt = CPU_ACC;
                end
            end
            CPU_ACC: begin
                if (!rend_active) begin
                    cpu_drive = 1'b1;
                    state_nxt = CPU_DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CPU_DONE: begin
                cpu_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= cpu_addr;
                we_q <= cpu_we;
                wd_q <= cpu_wdata;
            end
            if (cpu_ack && !we_q) begin
                rdata_q <= vram_rdata;
            end
        end
    end

    // Read data is bypassed during the ack cycle so it is valid alongside cpu_ack, then held in rdata_q.
    assign cpu_rdata  = (cpu_ack && !we_q) ? vram_rdata : rdata_q;

    assign vram_addr  = cpu_drive ? a_q : rend_addr;
    assign vram_we    = cpu_drive & we_q;
    assign vram_wdata = cpu_drive ? wd_q : '0;
    assign rend_data  = vram_rdata;
    assign busy       = (state != IDLE);

`ifdef VRAM_ARB_STATS_EN
    logic stall_inc;

    assign stall_inc = rend_active && (((state == IDLE) && cpu_req) || (state == CPU_ACC));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench for ppu_vram_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_ppu_vram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rend_active = 1'b0;
    logic [AW-1:0] rend_addr = 16'h1357;
    logic [DW-1:0] rend_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata = '0;
    logic          busy;
    logic [15:0]   stall_cnt;

    ppu_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rend_active(rend_active), .rend_addr(rend_addr), .rend_data(rend_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // VRAM: synchronous read, data one cycle after the address. Written only through vram_we.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        vram_rdata <= mem[vram_addr];
        if (vram_we) mem[vram_addr] <= vram_wdata;
    end

    // Reference: what memory must contain, according to the accesses the arbiter is allowed to commit.
    logic [7:0]  shadow [0:65535];
    bit          m_waiting = 0;   // accepted, waiting for a renderer-free cycle to use the bus
    bit          m_acking = 0;    // bus used last cycle, completion is signalled this cycle
    logic [15:0] m_addr = '0;
    bit          m_we = 0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  m_rdata = '0;
    int          m_stall = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_waiting = 0; m_acking = 0; m_addr = '0; m_we = 0; m_wd = '0; m_rdata = '0; m_stall = 0;
        end else if (m_acking) begin
            if (!m_we) m_rdata = shadow[m_addr];
            m_acking = 0;
        end else if (m_waiting) begin
            m_waiting = 0;
            if (rend_active) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                if (m_we) shadow[m_addr] = m_wd;
                m_acking = 1;
            end
        end else if (cpu_req) begin
            if (rend_active) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_addr = cpu_addr; m_we = cpu_we; m_wd = cpu_wdata; m_waiting = 1;
            end
        end
    end

    bit m_drive;
    always @(negedge clk) begin
        m_drive = m_waiting && !rend_active;
        chk("vram_addr",  32'(vram_addr),  32'(m_drive ? m_addr : rend_addr));
        chk("vram_we",    32'(vram_we),    32'(m_drive && m_we));
        chk("vram_wdata", 32'(vram_wdata), 32'(m_drive ? m_wd : 8'h00));
        chk("cpu_ack",    32'(cpu_ack),    32'(m_acking));
        chk("cpu_rdata",  32'(cpu_rdata),  32'((m_acking && !m_we) ? shadow[m_addr] : m_rdata));
        chk("busy",       32'(busy),       32'(m_waiting || m_acking));
        chk("rend_data",  32'(rend_data),  32'(vram_rdata));
        chk("stall_cnt",  32'(stall_cnt),  STATS ? 32'(m_stall) : 32'd0);
    end

    // Event monitor for the directed and transaction-level checks.
    int          we_cnt = 0;
    int          ack_cnt = 0;
    int          wr_ack_cnt = 0;
    bit          ack_prev = 0;
    logic [15:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;
    always @(negedge clk) begin
        if (vram_we) begin
            we_cnt++; last_we_addr = vram_addr; last_we_data = vram_wdata;
        end
        if (cpu_ack) begin
            ack_cnt++;
            if (cpu_we) wr_ack_cnt++;
        end
        ack_prev = cpu_ack;
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Called at posedge+2; lat counts the negedges after request until ack (0 = same cycle).
    task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d, output int lat);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!cpu_ack && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("ack_timeout", 32'(cpu_ack), 32'd1);
        step();
        cpu_req = 1'b0;
    endtask

    int lat;
    int n;
    int we0, ack0, st0, wa0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] <= init_val(16'(i));
            shadow[i] = init_val(16'(i));
        end
        mem[16'h23C1] <= 8'h3C;
        shadow[16'h23C1] = 8'h3C;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'h1357);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Idle write
        we0 = we_cnt;
        cpu_access(1'b1, 16'h2005, 8'hA5, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
        chk("wr_addr", 32'(last_we_addr), 32'h2005);
        chk("wr_data", 32'(last_we_data), 32'hA5);

        // Idle read, then hold across idle cycles and a write
        step();
        cpu_access(1'b0, 16'h23C1, 8'h00, lat);
        chk("rd_latency", 32'(lat), 32'd2);
        repeat (3) step();
        chk("rd_hold_idle", 32'(cpu_rdata), 32'h3C);
        cpu_access(1'b1, 16'h2006, 8'h11, lat);
        step();
        chk("rd_hold_after_wr", 32'(cpu_rdata), 32'h3C);

        // Renderer priority: 8 denied cycles, commit one cycle after rend_active falls
        we0 = we_cnt; st0 = int'(stall_cnt);
        rend_active = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2007; cpu_wdata = 8'h5C; cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rend_addr = 16'h0100 + 16'(i);
            step();
        end
        rend_active = 1'b0;
        @(negedge clk);
        chk("prio_no_we_yet", 32'(vram_we), 32'd0);
        chk("prio_no_we_during", 32'(we_cnt - we0), 32'd0);
        @(negedge clk);
        chk("prio_commit", 32'(vram_we), 32'd1);
        chk("prio_commit_addr", 32'(vram_addr), 32'h2007);
        n = 0;
        while (!cpu_ack && n < 100) begin @(negedge clk); n++; end
        chk("prio_ack_timeout", 32'(cpu_ack), 32'd1);
        step();
        cpu_req = 1'b0;
        chk("prio_stall", 32'(int'(stall_cnt) - st0), STATS ? 32'd8 : 32'd0);

        // Abort in CPU_ACC, then retry
        step();
        we0 = we_cnt; ack0 = ack_cnt; st0 = int'(stall_cnt);
        cpu_we = 1'b1; cpu_addr = 16'h2008; cpu_wdata = 8'h99; cpu_req = 1'b1;
        step();
        rend_active = 1'b1;
        @(negedge clk);
        chk("abort_no_we", 32'(vram_we), 32'd0);
        step();
        rend_active = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 100) begin @(negedge clk); n++; end
        chk("abort_ack_timeout", 32'(cpu_ack), 32'd1);
        step();
        cpu_req = 1'b0;
        repeat (4) step();
        chk("abort_one_we", 32'(we_cnt - we0), 32'd1);
        chk("abort_one_ack", 32'(ack_cnt - ack0), 32'd1);
        chk("abort_stall", 32'(int'(stall_cnt) - st0), STATS ? 32'd1 : 32'd0);

        // Back-to-back: req held through the ack
        cpu_we = 1'b0; cpu_addr = 16'h23C1; cpu_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 100) begin @(negedge clk); n++; end
        chk("b2b_first_lat", 32'(n), 32'd2);
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 100) begin @(negedge clk); n++; end
        chk("b2b_gap", 32'(n + 1), 32'd3);
        chk("b2b_rdata", 32'(cpu_rdata), 32'h3C);
        step();
        cpu_req = 1'b0;
        step();

        // Reset mid-access (write in CPU_ACC)
        ack0 = ack_cnt;
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77; cpu_req = 1'b1;
        step();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(vram_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(cpu_ack), 32'd0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
        cpu_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("mid_rst_no_ack", 32'(ack_cnt - ack0), 32'd0);
        chk("mid_rst_no_commit", 32'(mem[16'h1234]), 32'h7C);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        // Randomized traffic
        we0 = we_cnt; wa0 = wr_ack_cnt;
        for (int c = 0; c < 3000; c++) begin
            step();
            rend_active = ($urandom_range(0, 9) < 3);
            rend_addr = 16'($urandom);
            if (cpu_req) begin
                if (ack_prev && $urandom_range(0, 4) != 0) cpu_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_we = 1'($urandom);
                cpu_addr = 16'h2000 + 16'($urandom_range(0, 31));
                cpu_wdata = 8'($urandom);
                cpu_req = 1'b1;
            end
        end
        rend_active = 1'b0;
        n = 0;
        while (cpu_req && n < 100) begin
            step();
            if (ack_prev) cpu_req = 1'b0;
            n++;
        end
        chk("rand_drain_timeout", 32'(cpu_req), 32'd0);
        repeat (4) step();
        chk("rand_we_per_acked_write", 32'(we_cnt - we0), 32'(wr_ack_cnt - wa0));
        for (int a = 16'h2000; a < 16'h2020; a++) begin
            chk("rand_mem_contents", 32'(mem[a]), 32'(shadow[a]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
